dcache_ecc_monitor: RTL and testbench

DCACHE_ECC_MONITOR -- requirements
Module: dcache_ecc_monitor

---
 rtl/config_pkg.sv | 17 +
 rtl/dcache_ecc_monitor.sv | 153 +++++++++++++++
 tb/tb_dcache_ecc_monitor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// ============================================================================
// config_pkg : minimal core-configuration record used to size the monitor.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32};

endpackage

`default_nettype wire

// File: rtl/dcache_ecc_monitor.sv
// ============================================================================
// dcache_ecc_monitor : saturating dcache event counters, register read port
//                      and uncorrectable-ECC exception log FIFO.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module dcache_ecc_monitor #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned NumEvents = 6,
  parameter int unsigned CntWidth  = 32,
  parameter int unsigned LogDepth  = 4,
  parameter type exception_t = struct packed {
    logic [CVA6Cfg.XLEN-1:0] cause;
    logic [CVA6Cfg.XLEN-1:0] tval;
    logic                    valid;
  }
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NumEvents-1:0] counters_i,
  input  exception_t           uncorrectable_ex_i,
  input  logic                 clr_i,
  input  logic [NumEvents-1:0] clr_mask_i,
  input  logic                 rd_req_i,
  input  logic [2:0]           rd_addr_i,
  output logic                 rd_valid_o,
  output logic [CntWidth-1:0]  rd_data_o,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output exception_t           ex_o,
  output logic                 overflow_o,
  input  logic                 clr_overflow_i,
  output logic                 irq_o
);

  localparam int unsigned AW = (LogDepth > 1) ? $clog2(LogDepth) : 1;
  localparam int unsigned PW = AW + 1;
  // Status word is built at least 9 bits wide so the overflow bit always has a home.
  localparam int unsigned SW = (CntWidth > 9) ? CntWidth : 9;

  // ---------------------------------------------------------------- counters
  logic [CntWidth-1:0] cnt_q [NumEvents];
  logic [CntWidth-1:0] cnt_d [NumEvents];

  always_comb begin
    for (int k = 0; k < NumEvents; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_i && clr_mask_i[k]) begin
        cnt_d[k] = '0;
      end else if (enable_i && counters_i[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumEvents; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumEvents; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------- log FIFO
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  exception_t    mem_q [LogDepth];
  logic          fifo_full, fifo_empty;
  logic          push, pop, push_ok, drop;
  logic [PW-1:0] occupancy;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign occupancy  = wptr_q - rptr_q;

  assign push    = uncorrectable_ex_i.valid;
  assign pop     = !fifo_empty && ex_ready_i;
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  assign wptr_d = wptr_q + PW'(push_ok);
  assign rptr_d = rptr_q + PW'(pop);
  // A drop in the same cycle as a clear must leave the flag set.
  assign ovf_d  = drop | (ovf_q & ~clr_overflow_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= uncorrectable_ex_i;
    end
  end

  assign ex_valid_o = !fifo_empty;
  assign ex_o       = fifo_empty ? exception_t'('0) : mem_q[rptr_q[AW-1:0]];
  assign overflow_o = ovf_q;
  assign irq_o      = !fifo_empty || ovf_q;

  // ---------------------------------------------------------------- read port
  logic [SW-1:0]       status;
  logic [CntWidth-1:0] rd_mux;
  logic                rd_valid_q;
  logic [CntWidth-1:0] rd_data_q;

  always_comb begin
    status            = '0;
    status[8]         = ovf_q;
    status[PW-1:0]    = occupancy;
    rd_mux            = '0;
    if (rd_addr_i == 3'd6) begin
      rd_mux = status[CntWidth-1:0];
    end else if (rd_addr_i != 3'd7) begin
      for (int k = 0; k < NumEvents; k++) begin
        if ((k < 6) && (rd_addr_i == 3'(k))) begin
          rd_mux = cnt_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      rd_data_q  <= rd_req_i ? rd_mux : '0;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ecc_monitor.sv
// ============================================================================
// tb_dcache_ecc_monitor : scoreboard bench for dcache_ecc_monitor.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ecc_monitor;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } ex_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, rd_req = 1'b0, ex_ready = 1'b0, clr_ovf = 1'b0;
  logic [5:0]  ev = '0, clr_mask = '0;
  logic [2:0]  rd_addr = '0;
  ex_t         exv = '0;
  logic        rd_valid_o, ex_valid_o, overflow_o, irq_o;
  logic [31:0] rd_data_o;
  ex_t         ex_o;

  logic        s_en = 1'b0, s_rd_req = 1'b0;
  logic [5:0]  s_ev = '0;
  logic [2:0]  s_rd_addr = '0;
  ex_t         s_exv = '0;
  logic        s_rd_valid, s_ex_valid, s_ovf, s_irq;
  logic [3:0]  s_rd_data;
  ex_t         s_ex_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rd_exp_t     sbq[$];
  ex_t         exq[$];
  logic [31:0] mcnt [6];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_ecc_monitor #(.NumEvents(6), .CntWidth(32), .LogDepth(4), .exception_t(ex_t)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .counters_i(ev),
    .uncorrectable_ex_i(exv), .clr_i(clr), .clr_mask_i(clr_mask),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready), .ex_o(ex_o),
    .overflow_o(overflow_o), .clr_overflow_i(clr_ovf), .irq_o(irq_o)
  );

  dcache_ecc_monitor #(.NumEvents(6), .CntWidth(4), .LogDepth(4), .exception_t(ex_t)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(s_en), .counters_i(s_ev),
    .uncorrectable_ex_i(s_exv), .clr_i(1'b0), .clr_mask_i(6'b0),
    .rd_req_i(s_rd_req), .rd_addr_i(s_rd_addr), .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
    .ex_valid_o(s_ex_valid), .ex_ready_i(1'b0), .ex_o(s_ex_o),
    .overflow_o(s_ovf), .clr_overflow_i(1'b0), .irq_o(s_irq)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    if (a < 3'd6) v = mcnt[a];
    else if (a == 3'd6) v = {23'd0, m_ovf, 8'(exq.size())};
    return v;
  endfunction

  // Reads are scored on the falling edge: data and exact one-cycle latency.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid_o) begin
        if (sbq.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = sbq.pop_front();
          check("rd_due", cyc, e.due);
          check("rd_data", rd_data_o, e.data);
        end
      end else begin
        check("rd_idle_data", rd_data_o, 0);
        if (sbq.size() != 0 && sbq[0].due <= cyc) begin
          check("rd_missing", 0, 1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic step();
    logic is_pop, is_full, is_drop;
    ex_t  h;
    int   occ;
    occ = exq.size();
    check("ex_valid", ex_valid_o, occ != 0);
    check("overflow", overflow_o, m_ovf);
    check("irq", irq_o, (occ != 0) || m_ovf);
    if (occ == 0) check("ex_empty", ex_o, 0);
    else          check("ex_head_stable", ex_o, exq[0]);
    if (rd_req) sbq.push_back('{data: model_rd(rd_addr), due: cyc + 1});
    is_pop  = (occ != 0) && ex_ready;
    is_full = (occ == 4);
    is_drop = 1'b0;
    if (is_pop) begin
      h = exq.pop_front();
      check("ex_pop", ex_o, h);
    end
    if (exv.valid) begin
      if (!is_full || is_pop) exq.push_back(exv);
      else is_drop = 1'b1;
    end
    m_ovf = is_drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
    for (int k = 0; k < 6; k++) begin
      if (clr && clr_mask[k]) mcnt[k] = '0;
      else if (en && ev[k] && mcnt[k] != '1) mcnt[k] = mcnt[k] + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_req = 1'b1; rd_addr = a; step(); rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 6; k++) mcnt[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_ex_valid", ex_valid_o, 0);
    check("rst_ex_o", ex_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_irq", irq_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // saturate (4-bit counters)
    s_en = 1'b1; s_ev = 6'b000010;
    repeat (20) begin @(posedge clk); #1; end
    s_ev = '0; s_rd_req = 1'b1; s_rd_addr = 3'd1;
    @(posedge clk); #1;
    s_rd_req = 1'b0;
    check("sat_valid", s_rd_valid, 1);
    check("sat_data", s_rd_data, 15);
    @(posedge clk); #1;
    check("sat_idle_valid", s_rd_valid, 0);
    check("sat_idle_data", s_rd_data, 0);

    // count
    en = 1'b1; ev = 6'b000101;
    repeat (3) step();
    ev = '0;
    rd(3'd0); rd(3'd2); step();
    check("count_c0", mcnt[0], 3);

    // enable low holds
    en = 1'b0; ev = 6'b111111;
    repeat (2) step();
    ev = '0; rd(3'd0); rd(3'd1);

    // clear collision
    en = 1'b1; ev = 6'b000001;
    repeat (2) step();
    clr = 1'b1; clr_mask = 6'b000001; rd_req = 1'b1; rd_addr = 3'd0;
    step();
    clr = 1'b0; clr_mask = '0; ev = '0;
    rd(3'd0); rd(3'd2); rd(3'd7); step();

    // overflow
    ex_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exv = '{cause: 32'(i + 1), tval: $urandom, valid: 1'b1};
      step();
    end
    exv = '0;
    rd(3'd6); step();
    check("ovf_irq", irq_o, 1);

    // clear overflow, then clear colliding with a drop
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0; step();
    exv = '{cause: 32'h77, tval: $urandom, valid: 1'b1}; clr_ovf = 1'b1;
    step();
    exv = '0; clr_ovf = 1'b0; step();
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    // full push/pop
    exv = '{cause: 32'h99, tval: $urandom, valid: 1'b1}; ex_ready = 1'b1;
    step();
    exv = '0; ex_ready = 1'b0;
    rd(3'd6); step();
    ex_ready = 1'b1;
    repeat (4) step();
    ex_ready = 1'b0;
    repeat (2) step();

    // reset mid-read
    rd(3'd2);
    rst_n = 1'b0;
    sbq.delete(); exq.delete(); m_ovf = 1'b0;
    for (int k = 0; k < 6; k++) mcnt[k] = '0;
    @(posedge clk); #1;
    check("mid_rst_valid", rd_valid_o, 0);
    check("mid_rst_data", rd_data_o, 0);
    rst_n = 1'b1;
    en = 1'b0;
    repeat (3) step();
    for (int a = 0; a < 8; a++) rd(3'(a));
    repeat (2) step();
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
